// File: rtl/transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A one-entry holding buffer lets the next byte queue up so frames run back-to-back.
module transmitter #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int PARITY       = 0,      // 0 = none, 1 = even, 2 = odd
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txddata,
  input  logic       tvalid,
  output logic       tready,
  output logic       txd,
  output logic       tbusy,
  output logic       tdone
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic             buf_full_q, buf_full_d;
  logic [7:0]       buf_data_q, buf_data_d;

  logic bit_end;
  logic load;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    txd_d      = txd_q;
    done_d     = 1'b0;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    load       = 1'b0;
    bit_end    = (cnt_q == CNT_MAX);

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (buf_full_q) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
              idx_d   = 3'd0;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
          idx_d   = 3'd0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            done_d = 1'b1;
            // A queued byte starts its frame on this same edge: no idle gap.
            if (buf_full_q) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d    = S_START;
      cnt_d      = '0;
      shift_d    = buf_data_q;
      par_d      = (^buf_data_q) ^ ODD_PAR;
      txd_d      = 1'b0;
      buf_full_d = 1'b0;
    end

    // Accept needs an empty buffer before the edge, so it never collides with a load.
    if (tvalid && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_data_d = txddata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
      buf_full_q <= 1'b0;
      buf_data_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // pre-edge values, matching the hardware regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign tready = !buf_full_q;
  assign txd    = txd_q;
  assign tbusy  = (state_q != S_IDLE);
  assign tdone  = done_q;

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: four instances (8N1, 8E1, 8O1, 8N2) at 16 clocks per bit,
// each checked every cycle against a frame-level waveform model plus literal checks.
module tb_transmitter;

  localparam int CPB = 16;
  localparam int NI  = 4;

  function automatic int par_of(input int k);
    return (k == 1) ? 1 : (k == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  logic       clk;
  logic       rst_n;
  logic [7:0] txddata_r [NI];
  logic       tvalid_r  [NI];
  logic       tready_w  [NI];
  logic       txd_w     [NI];
  logic       tbusy_w   [NI];
  logic       tdone_w   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    transmitter #(
      .CLKS_PER_BIT(CPB),
      .PARITY      (par_of(g)),
      .STOP_BITS   (stop_of(g))
    ) u_dut (
      .clk    (clk),
      .rst    (rst_n),
      .txddata(txddata_r[g]),
      .tvalid (tvalid_r[g]),
      .tready (tready_w[g]),
      .txd    (txd_w[g]),
      .tbusy  (tbusy_w[g]),
      .tdone  (tdone_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Model: a per-instance queue of expected line cycles built from whole frames.
  typedef struct packed {
    logic txd;
    logic busy;
    logic first;
    logic last;
  } ent_t;

  localparam ent_t IDLE_E = '{txd: 1'b1, busy: 1'b0, first: 1'b0, last: 1'b0};

  ent_t mq   [NI][$];
  int   pend [NI];
  logic dnx  [NI];

  task automatic model_accept(input int k, input logic [7:0] b);
    logic [11:0] fb;
    int nb;
    fb = '0;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = b[i];
    nb = 9;
    if (par_of(k) != 0) begin
      fb[nb] = (^b) ^ (par_of(k) == 2);
      nb++;
    end
    for (int s = 0; s < stop_of(k); s++) begin
      fb[nb] = 1'b1;
      nb++;
    end
    // An idle line starts the frame one cycle after the accept edge.
    if (mq[k].size() == 0) mq[k].push_back(IDLE_E);
    for (int i = 0; i < nb; i++)
      for (int c = 0; c < CPB; c++)
        mq[k].push_back('{txd: fb[i], busy: 1'b1,
                          first: (i == 0 && c == 0), last: (i == nb - 1 && c == CPB - 1)});
    pend[k]++;
  endtask

  always @(negedge clk) begin
    ent_t e;
    logic ed;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        mq[k].delete();
        pend[k] = 0;
        dnx[k]  = 1'b0;
        e       = IDLE_E;
        ed      = 1'b0;
      end else begin
        ed     = dnx[k];
        e      = (mq[k].size() != 0) ? mq[k].pop_front() : IDLE_E;
        dnx[k] = e.last;
        if (e.first) pend[k]--;
      end
      check($sformatf("txd[%0d]", k),    32'(txd_w[k]),    32'(e.txd));
      check($sformatf("tbusy[%0d]", k),  32'(tbusy_w[k]),  32'(e.busy));
      check($sformatf("tdone[%0d]", k),  32'(tdone_w[k]),  32'(ed));
      check($sformatf("tready[%0d]", k), 32'(tready_w[k]), 32'(pend[k] == 0));
    end
  end

  // Holds tvalid until the byte is taken; returns just after the accept edge.
  task automatic send(input int k, input logic [7:0] b);
    logic rdy;
    txddata_r[k] = b;
    tvalid_r[k]  = 1'b1;
    for (int c = 0; c < 600; c++) begin
      rdy = tready_w[k];
      @(posedge clk);
      if (rdy) begin
        #1;
        model_accept(k, b);
        tvalid_r[k] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    tvalid_r[k] = 1'b0;
    timeout_fail($sformatf("send[%0d]", k));
  endtask

  // Samples each bit mid-cell from the first low negedge; n counts cycles from the start edge.
  task automatic capture(input int k, output logic [11:0] cap, output int done_n,
                         output logic txd_at_done, output logic busy_at_done);
    int w;
    cap = '0;
    done_n = -1;
    txd_at_done = 1'b1;
    busy_at_done = 1'b0;
    w = 0;
    @(negedge clk);
    while (txd_w[k] !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) begin
      timeout_fail($sformatf("start[%0d]", k));
      return;
    end
    for (int n = 0; n < 400; n++) begin
      if ((n % CPB) == CPB / 2 && (n / CPB) < 12) cap[n / CPB] = txd_w[k];
      if (tdone_w[k] === 1'b1) begin
        done_n       = n;
        txd_at_done  = txd_w[k];
        busy_at_done = tbusy_w[k];
        return;
      end
      @(negedge clk);
    end
    timeout_fail($sformatf("tdone[%0d]", k));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] cap;
    int          dn;
    logic        td, bd;

    for (int k = 0; k < NI; k++) begin
      txddata_r[k] = 8'h00;
      tvalid_r[k]  = 1'b0;
      pend[k]      = 0;
      dnx[k]       = 1'b0;
    end

    // Reset held two cycles, then idle outputs.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_txd",    32'(txd_w[0]),    32'd1);
    check("reset_tready", 32'(tready_w[0]), 32'd1);
    check("reset_tbusy",  32'(tbusy_w[0]),  32'd0);
    check("reset_tdone",  32'(tdone_w[0]),  32'd0);

    // Single 8N1 byte 0xA5.
    fork
      capture(0, cap, dn, td, bd);
      send(0, 8'hA5);
    join
    check("a5_bits",      32'(cap[9:0]), 32'h34A);
    check("a5_done_cyc",  32'(dn),       32'd160);
    check("a5_busy_done", 32'(bd),       32'd0);
    check("a5_txd_done",  32'(td),       32'd1);
    repeat (5) @(negedge clk);

    // Back-to-back 0x55, 0x0F (tvalid held), 0xC3.
    fork
      capture(0, cap, dn, td, bd);
      begin
        send(0, 8'h55);
        send(0, 8'h0F);
        send(0, 8'hC3);
      end
    join
    check("b2b_bits",      32'(cap[9:0]), 32'h2AA);
    check("b2b_done_cyc",  32'(dn),       32'd160);
    check("b2b_no_gap",    32'(td),       32'd0);
    check("b2b_busy_held", 32'(bd),       32'd1);
    repeat (360) @(negedge clk);

    // Parity: even 0x07 -> 1, even 0x00 -> 0, odd 0x07 -> 0.
    fork
      begin : br_even
        logic [11:0] c1;
        int          d1;
        logic        t1, b1;
        fork
          capture(1, c1, d1, t1, b1);
          send(1, 8'h07);
        join
        check("even07_par",  32'(c1[9]),  32'd1);
        check("even07_stop", 32'(c1[10]), 32'd1);
        check("even07_done", 32'(d1),     32'd176);
        repeat (3) @(negedge clk);
        fork
          capture(1, c1, d1, t1, b1);
          send(1, 8'h00);
        join
        check("even00_par",  32'(c1[9]), 32'd0);
        check("even00_done", 32'(d1),    32'd176);
      end
      begin : br_odd
        logic [11:0] c2;
        int          d2;
        logic        t2, b2;
        fork
          capture(2, c2, d2, t2, b2);
          send(2, 8'h07);
        join
        check("odd07_par",  32'(c2[9]), 32'd0);
        check("odd07_done", 32'(d2),    32'd176);
      end
    join
    repeat (5) @(negedge clk);

    // Two stop bits with 0xFF.
    fork
      capture(3, cap, dn, td, bd);
      send(3, 8'hFF);
    join
    check("stop2_bit9",  32'(cap[9]),  32'd1);
    check("stop2_bit10", 32'(cap[10]), 32'd1);
    check("stop2_done",  32'(dn),      32'd176);
    repeat (5) @(negedge clk);

    // Reset during data bit 0 of 0x3C with 0x81 buffered: frame and buffer are dropped.
    send(0, 8'h3C);
    send(0, 8'h81);
    repeat (20) @(negedge clk);
    #2;
    check("pre_rst_txd",    32'(txd_w[0]),    32'd0);
    check("pre_rst_tready", 32'(tready_w[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_txd_now",    32'(txd_w[0]),    32'd1);
    check("rst_tready_now", 32'(tready_w[0]), 32'd1);
    check("rst_tbusy_now",  32'(tbusy_w[0]),  32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
